piso_shifter: RTL and testbench

- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in/parallel-out shift register (sfr).
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on a serial line, with a bit-valid qualifier and an end-of-word marker.
- Feeds the sfr block, or any serial sink, in loopback and link tests.

---
 rtl/piso_shifter.sv | 100 ++++++++++
 tb/tb_piso_shifter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter: takes a WIDTH-bit word over valid/ready and emits it
// one bit per clock with valid/last qualifiers. Optional even-parity trailer: PISO_PARITY_EN.
module piso_shifter #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_d,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head_bit;
  logic             accept;

  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign accept   = i_valid && o_ready;

  // All outputs come from registered state only.
  assign o_valid = (state_q == SHIFT);
  assign o_busy  = (state_q == SHIFT);
  assign o_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign o_ready = (state_q == IDLE) || o_last;

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = ^i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  // The trailer bit occupies the slot after the last data bit.
  assign o_d = (state_q == SHIFT) &&
               ((cnt_q == CW'(WIDTH)) ? parity_q : head_bit);
`else
  assign o_d = (state_q == SHIFT) && head_bit;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = i_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // A word accepted on the final bit starts with no gap.
          cnt_d = '0;
          if (accept) shreg_d = i_data;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: an MSB-first and an LSB-first instance share the
// same stimulus; expected serial streams are written out by hand.
module tb_piso_shifter;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         valid;

  logic m_ready, m_d, m_valid, m_last, m_busy;
  logic l_ready, l_d, l_valid, l_last, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(m_ready), .o_d(m_d), .o_valid(m_valid), .o_last(m_last), .o_busy(m_busy)
  );

  piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
    .o_ready(l_ready), .o_d(l_d), .o_valid(l_valid), .o_last(l_last), .o_busy(l_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " m_valid"}, m_valid, 1'b0);
    chk({tag, " m_d"},     m_d,     1'b0);
    chk({tag, " m_busy"},  m_busy,  1'b0);
    chk({tag, " m_ready"}, m_ready, 1'b1);
    chk({tag, " m_last"},  m_last,  1'b0);
    chk({tag, " l_valid"}, l_valid, 1'b0);
    chk({tag, " l_d"},     l_d,     1'b0);
    chk({tag, " l_ready"}, l_ready, 1'b1);
  endtask

  task automatic chk_bit(input string tag, input logic em, input logic el, input logic elast);
    chk({tag, " m_valid"}, m_valid, 1'b1);
    chk({tag, " m_busy"},  m_busy,  1'b1);
    chk({tag, " m_d"},     m_d,     em);
    chk({tag, " m_last"},  m_last,  elast);
    chk({tag, " m_ready"}, m_ready, elast);
    chk({tag, " l_valid"}, l_valid, 1'b1);
    chk({tag, " l_d"},     l_d,     el);
    chk({tag, " l_last"},  l_last,  elast);
  endtask

  // exp_m / exp_l list the data bits in transmit order, first bit at index W-1.
  task automatic run_word(input string tag, input logic [W-1:0] w,
                          input logic [W-1:0] exp_m, input logic [W-1:0] exp_l,
                          input logic par);
    data  = w;
    valid = 1'b1;
    tick();
    for (int k = 0; k < NB; k++) begin
      if (k < W) chk_bit($sformatf("%s bit%0d", tag, k), exp_m[W-1-k], exp_l[W-1-k], k == NB-1);
      else       chk_bit($sformatf("%s par", tag), par, par, 1'b1);
      $display("%s: cycle %0d m_d=%0b l_d=%0b last=%0b", tag, k, m_d, l_d, m_last);
      // Don't-care inputs while busy; must not leak into the word in flight.
      data  = W'($urandom);
      valid = (k < NB-1) ? 1'($urandom) : 1'b0;
      tick();
    end
    chk_idle({tag, " after"});
  endtask

  initial begin
    logic [2*W-1:0] b2b_m;
    logic [2*W-1:0] b2b_l;
    logic           em, el;
    int             j;

    // Reset with a handshake presented: nothing may be accepted.
    rst = 1'b1; valid = 1'b1; data = 4'hF;
    tick(); chk_idle("reset1");
    tick(); chk_idle("reset2");
    $display("reset: m_valid=%0b m_ready=%0b", m_valid, m_ready);
    rst = 1'b0; valid = 1'b0;
    tick(); chk_idle("post_reset");

    // Single word 4'hA: MSB 1010, LSB 0101, parity 0.
    run_word("word_A", 4'hA, 4'b1010, 4'b0101, 1'b0);

    // Back-to-back 4'hC then 4'h3 with i_valid held high.
    b2b_m = 8'b1100_0011;
    b2b_l = 8'b0011_1100;
    data  = 4'hC;
    valid = 1'b1;
    tick();
    data = 4'h3;
    for (int k = 0; k < 2*NB; k++) begin
      j = k % NB;
      if (j < W) begin
        em = b2b_m[2*W-1 - ((k / NB) * W + j)];
        el = b2b_l[2*W-1 - ((k / NB) * W + j)];
      end else begin
        em = 1'b0;
        el = 1'b0;
      end
      chk_bit($sformatf("b2b bit%0d", k), em, el, j == NB-1);
      $display("b2b: cycle %0d m_d=%0b l_d=%0b ready=%0b", k, m_d, l_d, m_ready);
      valid = (k < NB);
      tick();
    end
    chk_idle("b2b after");

    // Mid-word reset after two bits of 4'hF.
    data  = 4'hF;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk_bit("mrst bit0", 1'b1, 1'b1, 1'b0);
    tick();
    chk_bit("mrst bit1", 1'b1, 1'b1, 1'b0);
    rst = 1'b1; valid = 1'b1;
    tick();
    chk_idle("mrst rst");
    $display("mid-word reset: m_valid=%0b", m_valid);
    rst = 1'b0; valid = 1'b0;
    tick(); chk_idle("mrst idle1");
    tick(); chk_idle("mrst idle2");
    run_word("word_9", 4'h9, 4'b1001, 4'b1001, 1'b0);

    // Parity-bearing words: 7 -> parity 1, 5 -> parity 0.
    run_word("word_7", 4'h7, 4'b0111, 4'b1110, 1'b1);
    run_word("word_5", 4'h5, 4'b0101, 4'b1010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
